// File: rtl/fps_meter_pkg.sv
// Shared Game Boy timing constants (gb_timing) and BCD helpers for fps_meter.
package fps_meter_pkg;

  // One calibrated second of the 3.287 MHz clock, shared with LED blink timing.
  localparam int GB_CLOCKS_PER_SEC = 3287000;
  // Nominal Game Boy frame-rate bounds.
  localparam int GB_FPS_MIN        = 59;
  localparam int GB_FPS_MAX        = 60;
  // Three BCD digits: hundreds, tens, ones.
  localparam int BCD_W             = 12;

  typedef enum logic [1:0] {
    BCD_IDLE    = 2'd0,
    BCD_CONVERT = 2'd1,
    BCD_DONE    = 2'd2
  } bcd_state_e;

  // Double-dabble correction: add 3 to every digit that is 5 or more.
  function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int k = 0; k < BCD_W / 4; k++) begin
      if (r[4*k +: 4] >= 4'd5) r[4*k +: 4] = r[4*k +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/fps_meter_if.sv
// VSYNC input and measurement outputs of fps_meter, grouped as one bus.
interface fps_meter_if #(
  parameter int COUNT_WIDTH = 8
);
  logic                   VSYNC;
  logic [COUNT_WIDTH-1:0] FPS_VALUE;
  logic [11:0]            FPS_BCD;
  logic                   FPS_VALID;
  logic                   LED_SEC;
  logic                   LED_OK;

  // Capture side / debug consumer.
  modport master (
    output VSYNC,
    input  FPS_VALUE, FPS_BCD, FPS_VALID, LED_SEC, LED_OK
  );

  // The meter itself.
  modport slave (
    input  VSYNC,
    output FPS_VALUE, FPS_BCD, FPS_VALID, LED_SEC, LED_OK
  );
endinterface

// File: rtl/fps_meter_bin2bcd_seq.sv
// Sequential binary-to-BCD converter: one double-dabble step per cycle.
module bin2bcd_seq
  import fps_meter_pkg::*;
#(
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [COUNT_WIDTH-1:0] bin_i,
  output logic [BCD_W-1:0]       bcd_o,
  output logic                   done_o
);

  localparam int IW = $clog2(COUNT_WIDTH + 1);
  localparam logic [IW-1:0] ITER_LAST = IW'(COUNT_WIDTH - 1);

  bcd_state_e             state_q, state_d;
  logic [COUNT_WIDTH-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]       acc_q, acc_d;
  logic [BCD_W-1:0]       bcd_q, bcd_d;
  logic [IW-1:0]          iter_q, iter_d;
  logic                   done_q, done_d;
  logic [BCD_W-1:0]       adj;

  // Next state and datapath: latch input on start, shift MSB-first, publish in DONE.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    acc_d   = acc_q;
    bcd_d   = bcd_q;
    iter_d  = iter_q;
    done_d  = 1'b0;
    adj     = bcd_add3(acc_q);
    case (state_q)
      BCD_IDLE: begin
        if (start_i) begin
          bin_d   = bin_i;
          acc_d   = '0;
          iter_d  = '0;
          state_d = BCD_CONVERT;
        end
      end
      BCD_CONVERT: begin
        acc_d  = {adj[BCD_W-2:0], bin_q[COUNT_WIDTH-1]};
        bin_d  = bin_q << 1;
        iter_d = iter_q + IW'(1);
        if (iter_q == ITER_LAST) state_d = BCD_DONE;
      end
      BCD_DONE: begin
        bcd_d   = acc_q;
        done_d  = 1'b1;
        state_d = BCD_IDLE;
      end
      default: state_d = BCD_IDLE;
    endcase
  end

  // State register; reset drops any conversion in flight without a done pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= BCD_IDLE;
      bin_q   <= '0;
      acc_q   <= '0;
      bcd_q   <= '0;
      iter_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      acc_q   <= acc_d;
      bcd_q   <= bcd_d;
      iter_q  <= iter_d;
      done_q  <= done_d;
    end
  end

  assign bcd_o  = bcd_q;
  assign done_o = done_q;

endmodule

// File: rtl/fps_meter.sv
// Frame-rate meter: counts VSYNC rising edges per one-second window.
module fps_meter
  import fps_meter_pkg::*;
#(
  parameter int CLOCKS_PER_SEC = GB_CLOCKS_PER_SEC,
  parameter int COUNT_WIDTH    = 8,
  parameter int MIN_OK         = GB_FPS_MIN,
  parameter int MAX_OK         = GB_FPS_MAX
) (
  input  logic       CLK_3P3_MHZ,
  input  logic       RST,
  fps_meter_if.slave bus
);

  localparam int TW = $clog2(CLOCKS_PER_SEC);
  localparam logic [TW-1:0]          T_LAST  = TW'(CLOCKS_PER_SEC - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [COUNT_WIDTH-1:0] MIN_C   = COUNT_WIDTH'(MIN_OK);
  localparam logic [COUNT_WIDTH-1:0] MAX_C   = COUNT_WIDTH'(MAX_OK);

  logic                   vsync_q;
  logic [TW-1:0]          timer_q, timer_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0] fps_value_q, fps_value_d;
  logic                   led_sec_q, led_sec_d;
  logic                   led_ok_q, led_ok_d;
  logic                   rise, term;
  logic [COUNT_WIDTH-1:0] final_cnt;

  // Edge detect, window timer and saturating count; a terminal-cycle edge closes with its window.
  always_comb begin
    rise        = bus.VSYNC & ~vsync_q;
    term        = (timer_q == T_LAST);
    final_cnt   = (rise && cnt_q != CNT_MAX) ? cnt_q + COUNT_WIDTH'(1) : cnt_q;
    timer_d     = term ? '0 : timer_q + TW'(1);
    cnt_d       = term ? '0 : final_cnt;
    fps_value_d = term ? final_cnt : fps_value_q;
    led_sec_d   = led_sec_q ^ term;
    led_ok_d    = (fps_value_q >= MIN_C) && (fps_value_q <= MAX_C);
  end

  // vsync_q resets high so a VSYNC held high through reset is not seen as an edge.
  always_ff @(posedge CLK_3P3_MHZ) begin
    if (RST) begin
      vsync_q     <= 1'b1;
      timer_q     <= '0;
      cnt_q       <= '0;
      fps_value_q <= '0;
      led_sec_q   <= 1'b0;
      led_ok_q    <= 1'b0;
    end else begin
      vsync_q     <= bus.VSYNC;
      timer_q     <= timer_d;
      cnt_q       <= cnt_d;
      fps_value_q <= fps_value_d;
      led_sec_q   <= led_sec_d;
      led_ok_q    <= led_ok_d;
    end
  end

  // Converter sees the same final count that FPS_VALUE latches.
  bin2bcd_seq #(
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_bcd (
    .clk_i   (CLK_3P3_MHZ),
    .rst_i   (RST),
    .start_i (term),
    .bin_i   (final_cnt),
    .bcd_o   (bus.FPS_BCD),
    .done_o  (bus.FPS_VALID)
  );

  assign bus.FPS_VALUE = fps_value_q;
  assign bus.LED_SEC   = led_sec_q;
  assign bus.LED_OK    = led_ok_q;

endmodule

// File: tb/tb_fps_meter.sv
// Randomized self-checking bench for fps_meter: two instances (100- and 600-cycle windows).
module tb_fps_meter;

  localparam int CPS_A = 100;
  localparam int CPS_B = 600;
  localparam int CW    = 8;
  localparam int NW    = 64;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  fps_meter_if #(.COUNT_WIDTH(CW)) ifa ();
  fps_meter_if #(.COUNT_WIDTH(CW)) ifb ();

  fps_meter #(.CLOCKS_PER_SEC(CPS_A), .COUNT_WIDTH(CW), .MIN_OK(59), .MAX_OK(60))
    u_a (.CLK_3P3_MHZ(clk), .RST(rst_a), .bus(ifa));
  fps_meter #(.CLOCKS_PER_SEC(CPS_B), .COUNT_WIDTH(CW), .MIN_OK(59), .MAX_OK(60))
    u_b (.CLK_3P3_MHZ(clk), .RST(rst_b), .bus(ifb));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Per instance: cycle index since reset release, VSYNC history, edges per window.
  int cyc[2];
  bit pvs[2];
  bit rstp[2];
  bit act[2];
  int wc[2][NW];
  int lastfps[2];

  function automatic int sat(input int n);
    return (n > 255) ? 255 : n;
  endfunction

  function automatic int to_bcd(input int v);
    return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  function automatic int inr(input int v);
    return (v >= 59 && v <= 60) ? 1 : 0;
  endfunction

  task automatic mon(input int id, input int cps, input logic rst_now, input logic vs,
                     input logic [7:0] fv, input logic [11:0] fb, input logic fval,
                     input logic ls, input logic lo);
    string nm;
    int c, w, ef, eb, wi;
    nm = (id == 1) ? "B" : "A";
    if (rstp[id]) begin
      chk({nm, " rst_fps"}, 32'(fv), 0);
      chk({nm, " rst_bcd"}, 32'(fb), 0);
      chk({nm, " rst_vld"}, 32'(fval), 0);
      chk({nm, " rst_sec"}, 32'(ls), 0);
      chk({nm, " rst_ok"},  32'(lo), 0);
      cyc[id] = 0;
      pvs[id] = 1'b1;
      for (int k = 0; k < NW; k++) wc[id][k] = 0;
      lastfps[id] = 0;
      act[id] = 1'b1;
    end
    if (act[id] && !(rstp[id] && rst_now)) begin
      c = cyc[id];
      if (vs && !pvs[id]) begin
        w = c / cps;
        if (w < NW) wc[id][w]++;
      end
      pvs[id] = vs;
      wi = c / cps - 1;
      ef = (c >= cps && wi < NW) ? sat(wc[id][wi]) : 0;
      chk({nm, " fps"}, 32'(fv), 32'(ef));
      chk({nm, " sec"}, 32'(ls), 32'((c / cps) % 2));
      chk({nm, " ok"},  32'(lo), 32'(inr(lastfps[id])));
      chk({nm, " vld"}, 32'(fval), 32'((c >= cps && (c % cps) == 9) ? 1 : 0));
      wi = (c - 9) / cps - 1;
      eb = (c >= cps + 9 && wi < NW) ? to_bcd(sat(wc[id][wi])) : 0;
      chk({nm, " bcd"}, 32'(fb), 32'(eb));
      lastfps[id] = ef;
      cyc[id] = c + 1;
    end
    rstp[id] = rst_now;
  endtask

  always @(negedge clk) begin
    mon(0, CPS_A, rst_a, ifa.VSYNC, ifa.FPS_VALUE, ifa.FPS_BCD, ifa.FPS_VALID, ifa.LED_SEC, ifa.LED_OK);
    mon(1, CPS_B, rst_b, ifb.VSYNC, ifb.FPS_VALUE, ifb.FPS_BCD, ifb.FPS_VALID, ifb.LED_SEC, ifb.LED_OK);
  end

  // ---------------- stimulus ----------------
  // 0 high, 1 pulse/10, 2 boundary (last edge on terminal cycle), 3 random,
  // 4 toggle every cycle, 5 exactly n edges
  function automatic logic pat(input int mode, input int i, input int n);
    case (mode)
      0: return 1'b1;
      1: return (i % 10 == 0);
      2: return ((i < 90) && (i % 10 == 0)) || (i == 99);
      3: return logic'($urandom_range(0, 1));
      4: return logic'(i % 2);
      5: return (i % 2 == 1) && (i / 2 < n);
      default: return 1'b0;
    endcase
  endfunction

  task automatic drv_a(input logic r, input logic v);
    @(posedge clk); #1;
    rst_a = r; ifa.VSYNC = v;
  endtask

  task automatic drv_b(input logic r, input logic v);
    @(posedge clk); #1;
    rst_b = r; ifb.VSYNC = v;
  endtask

  task automatic win_a(input int mode);
    for (int i = 0; i < CPS_A; i++) drv_a(1'b0, pat(mode, i, 0));
  endtask

  task automatic win_b(input int mode, input int n);
    for (int i = 0; i < CPS_B; i++) drv_b(1'b0, pat(mode, i, n));
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    ifa.VSYNC = 1'b1; ifb.VSYNC = 1'b1;
    fork
      begin
        repeat (5) drv_a(1'b1, 1'b1);
        win_a(0);
        win_a(1);
        win_a(1);
        win_a(2);
        win_a(1);
        win_a(3);
        win_a(3);
        // reset lands three cycles into the conversion of the window just closed
        drv_a(1'b0, 1'b0);
        drv_a(1'b0, 1'b0);
        drv_a(1'b1, 1'b0);
        drv_a(1'b1, 1'b1);
        drv_a(1'b1, 1'b1);
        win_a(1);
        win_a(2);
        repeat (12) drv_a(1'b0, 1'b0);
      end
      begin
        repeat (5) drv_b(1'b1, 1'b1);
        win_b(0, 0);
        win_b(4, 0);
        win_b(5, 60);
        win_b(5, 58);
        win_b(5, 61);
        win_b(5, 59);
        win_b(3, 0);
        repeat (12) drv_b(1'b0, 1'b0);
      end
    join
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fps_meter.md
# fps_meter

Measures the Game Boy LCD frame rate by counting VSYNC rising edges inside a calibrated one-second window. The window length is the same 3.287 MHz-derived second used by the LED blink timing. At each window end the block latches the frame count and converts it to BCD for display/debug. It also drives a heartbeat LED and an "in spec" LED. It sits downstream of the LCD signal capture and upstream of the debug display/LED pins.

## Interface
- CLOCKS_PER_SEC, 3287000: window length in clock cycles; must be ≥ 16.
- COUNT_WIDTH, 8: frame counter / result width; counts saturate at 2^COUNT_WIDTH−1.
- MIN_OK, 59: lowest frame count that sets LED_OK.
- MAX_OK, 60: highest frame count that sets LED_OK.

Ports:
- CLK_3P3_MHZ  in  1  system clock, ~3.3 MHz.
- RST  in  1  synchronous, active-high reset.
- VSYNC  in  1  Game Boy VSYNC, already synchronised to CLK_3P3_MHZ.
- FPS_VALUE  out  COUNT_WIDTH  frame count of the last completed window, binary.
- FPS_BCD  out  12  hundreds[11:8], tens[7:4], ones[3:0] of FPS_VALUE.
- FPS_VALID  out  1  one-cycle pulse when FPS_BCD is updated.
- LED_SEC  out  1  toggles at every window end (1 s heartbeat).
- LED_OK  out  1  high while MIN_OK ≤ FPS_VALUE ≤ MAX_OK.

## Operation
- **Edge detect:** register VSYNC into vsync_q, which resets to 1 so that VSYNC held high through reset is not counted. A rising edge is VSYNC & ~vsync_q.
- **Window timer:** counts 0..CLOCKS_PER_SEC−1. The terminal cycle is the cycle where the timer equals CLOCKS_PER_SEC−1. On the terminal cycle the timer wraps to 0.
- **Frame counter:**
  - Increments on each rising edge.
  - Saturates at 2^COUNT_WIDTH−1; it never wraps.
  - An edge on the terminal cycle is included in the closing window's count.
  - On the terminal cycle the counter restarts at 0. No edge from the closing window carries into the next window.
- **On the terminal cycle:**
  - FPS_VALUE ← final count, including any same-cycle edge.
  - LED_SEC toggles.
  - The BCD converter starts.
- **BCD conversion:** sequential double-dabble, one bit per cycle, COUNT_WIDTH iterations. FSM:
  - IDLE → CONVERT on window end.
  - CONVERT holds for COUNT_WIDTH cycles, each cycle doing add-3 on every digit ≥ 5, then shift-left.
  - CONVERT → DONE. In DONE, FPS_BCD is loaded, FPS_VALID = 1, then the FSM returns to IDLE.
  - A new window end cannot arrive while converting, because CLOCKS_PER_SEC ≥ 16.
- **LED_OK:** registered compare of FPS_VALUE, updated the cycle after FPS_VALUE changes.
- **Reset (any state, including mid-CONVERT):**
  - Timer, frame counter and FSM state go to 0 / IDLE; vsync_q goes to 1.
  - All outputs go to 0.
  - A conversion aborted by reset never produces FPS_VALID.
  - The first window after reset is a full CLOCKS_PER_SEC cycles long.

## Timing
- Window end at the edge closing cycle T:
  - FPS_VALUE and LED_SEC change, visible in cycle T+1.
  - LED_OK updates in T+2.
  - FPS_BCD updates and FPS_VALID pulses in cycle T+1+COUNT_WIDTH+1, i.e. T+10 for COUNT_WIDTH=8.
- FPS_VALID is high for exactly one cycle per window.
- FPS_BCD and FPS_VALUE hold between updates.
- Edge detect adds one cycle: VSYNC rising in cycle n is counted at the edge closing cycle n.

## Structure
- Shared constants package/include `gb_timing`:
  - CLOCKS_PER_SEC = 3287000, shared with the LED calibration logic.
  - GB nominal frame-rate bounds 59/60, used for MIN_OK/MAX_OK.
- One sub-module, `bin2bcd_seq`:
  - Inputs: start, bin[COUNT_WIDTH].
  - Outputs: bcd[12], done pulse.
  - Contains the IDLE/CONVERT/DONE FSM.
- fps_meter itself holds the edge detect, window timer, frame counter and LED logic.

## Test plan
All scenarios use CLOCKS_PER_SEC=100 unless noted.
- **Reset values:** hold RST with VSYNC=1 → all outputs 0 and no count recorded. Release RST and keep VSYNC high for 100 cycles → FPS_VALUE=0.
- **Basic count:** VSYNC pulses every 10 cycles → FPS_VALUE=10; FPS_BCD=0x010 with FPS_VALID pulse 9 cycles after FPS_VALUE changes; LED_SEC toggles every 100 cycles.
- **Saturation:** CLOCKS_PER_SEC=600, VSYNC toggles every cycle (300 edges) → FPS_VALUE=255, FPS_BCD=0x255.
- **LED_OK:** 60 edges per window → FPS_VALUE=60, LED_OK=1. Next window 58 edges → LED_OK=0. Next window 61 edges → LED_OK=0.
- **Boundary edge:** VSYNC rises so its edge lands on the terminal cycle → counted in the closing window (count N+1); next window starts at 0.
- **Reset mid-conversion:** assert RST 3 cycles into CONVERT → no FPS_VALID pulse, all outputs 0. The next window end occurs exactly 100 cycles after RST deasserts.
